// File: rtl/cpu_pkg.sv
// Shared types and encodings for the CPU controller and its decoder.
package cpu_pkg;

  // Controller FSM states
  typedef enum logic [2:0] {
    WAIT,
    DECODE,
    GET_A,
    GET_B,
    ALU,
    WR_IMM,
    WR_REG
  } state_t;

  // Instruction classes recognised by the decoder
  typedef enum logic [2:0] {
    CLS_UNDEF,
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_MVN,
    CLS_ADD,
    CLS_CMP,
    CLS_AND
  } instr_class_t;

  // Opcode field values
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Op field values within each opcode
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // Writeback source selects
  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;

  // ALU operations
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// Instruction decoder: splits the IR into fields, sign-extends the
// immediates and classifies the instruction for the controller FSM.
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0]  ir,
  output instr_class_t instr_class,
  output logic [1:0]   op,
  output logic [2:0]   rn,
  output logic [2:0]   rd,
  output logic [2:0]   rm,
  output logic [1:0]   sh,
  output logic [15:0]  sximm8,
  output logic [15:0]  sximm5
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  // Map opcode/op pairs onto instruction classes; anything unlisted is undefined
  always_comb begin
    instr_class = CLS_UNDEF;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)
        instr_class = CLS_MOV_IMM;
      else if (op == OP_MOV_REG)
        instr_class = CLS_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  instr_class = CLS_ADD;
        OP_CMP:  instr_class = CLS_CMP;
        OP_AND:  instr_class = CLS_AND;
        default: instr_class = CLS_MVN;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// CPU controller: instruction register plus a Moore FSM that sequences
// the datapath strobes for MOV/MVN/ADD/CMP/AND instructions.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  state_t       state;
  state_t       state_next;
  logic [15:0]  ir;
  instr_class_t instr_class;
  logic [1:0]   op;
  logic [2:0]   rn;
  logic [2:0]   rd;
  logic [2:0]   rm;
  logic [1:0]   sh;

  instr_dec u_dec (
    .ir          (ir),
    .instr_class (instr_class),
    .op          (op),
    .rn          (rn),
    .rd          (rd),
    .rm          (rm),
    .sh          (sh),
    .sximm8      (sximm8),
    .sximm5      (sximm5)
  );

  // Instruction register; only accepts a new word while the FSM is idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ir <= 16'h0000;
    else if (load && (state == WAIT))
      ir <= in;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= WAIT;
    else
      state <= state_next;
  end

  // Next-state and Moore outputs, all quiet unless the state says otherwise
  always_comb begin
    state_next = state;
    w          = 1'b0;
    readnum    = 3'b000;
    writenum   = 3'b000;
    write      = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    vsel       = VSEL_C;
    shift      = 2'b00;
    ALUop      = ALU_ADD;
    case (state)
      WAIT: begin
        w = 1'b1;
        if (s)
          state_next = DECODE;
      end
      DECODE: begin
        case (instr_class)
          CLS_MOV_IMM:                state_next = WR_IMM;
          CLS_MOV_REG, CLS_MVN:       state_next = GET_B;
          CLS_ADD, CLS_CMP, CLS_AND:  state_next = GET_A;
          default:                    state_next = WAIT;
        endcase
      end
      GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        state_next = GET_B;
      end
      GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        state_next = ALU;
      end
      ALU: begin
        shift = sh;
        bsel  = 1'b0;
        asel  = (instr_class == CLS_MOV_REG) || (instr_class == CLS_MVN);
        ALUop = (instr_class == CLS_MOV_REG) ? ALU_ADD : op;
        if (instr_class == CLS_CMP) begin
          loads      = 1'b1;
          state_next = WAIT;
        end else begin
          loadc      = 1'b1;
          state_next = WR_REG;
        end
      end
      WR_REG: begin
        vsel       = VSEL_C;
        writenum   = rd;
        write      = 1'b1;
        state_next = WAIT;
      end
      WR_IMM: begin
        vsel       = VSEL_IMM8;
        writenum   = rn;
        write      = 1'b1;
        state_next = WAIT;
      end
      default: state_next = WAIT;
    endcase
  end

endmodule
